// File: rtl/serial_console_endpoint_pkg.sv
// Shared constants and helpers for the serial console endpoint.
// Byte width and default FIFO depth live here so the top and the FIFO agree on them.
package serial_console_endpoint_pkg;

    localparam int SERIAL_DATA_W             = 8;
    localparam int SERIAL_DEPTH_LOG2_DEFAULT = 4;

    typedef struct packed {
        logic not_empty;
        logic not_full;
    } fifo_status_t;

    // Sticky flag update: a new error in the same cycle as a clear wins.
    function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO: head_data is read combinationally from the
// registered read pointer; all status is derived from registered state only.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic [DATA_W-1:0]   push_data,
    input  logic                pop,
    output logic [DATA_W-1:0]   head_data,
    output logic                not_empty,
    output logic                not_full,
    output logic [DEPTH_LOG2:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign not_empty = (count != '0);
    assign not_full  = (count != FULL_CNT);
    assign head_data = mem[rd_ptr];

    // Acceptance is judged on the start-of-cycle count: full pops only, empty pushes only.
    assign do_push = push && not_full;
    assign do_pop  = pop && not_empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_console_endpoint.sv
// Device-side endpoint for the processor byte serial port: TX FIFO toward the
// host, RX FIFO toward the processor, plus sticky overflow/underrun flags.
module serial_console_endpoint
    import serial_console_endpoint_pkg::*;
#(
    parameter int DEPTH_LOG2 = SERIAL_DEPTH_LOG2_DEFAULT,
    parameter int DATA_W     = SERIAL_DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   proc_wr_data,
    input  logic                proc_wren,
    input  logic                proc_rden,
    output logic [DATA_W-1:0]   proc_rd_data,
    output logic                proc_valid,
    output logic                proc_ready,
    output logic [DATA_W-1:0]   host_tx_data,
    output logic                host_tx_valid,
    input  logic                host_tx_ready,
    input  logic [DATA_W-1:0]   host_rx_data,
    input  logic                host_rx_valid,
    output logic                host_rx_ready,
    output logic [DEPTH_LOG2:0] tx_count,
    output logic [DEPTH_LOG2:0] rx_count,
    output logic                err_overflow,
    output logic                err_underrun,
    input  logic                err_clear
);

    fifo_status_t tx_st;
    fifo_status_t rx_st;

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (proc_wren),
        .push_data (proc_wr_data),
        .pop       (host_tx_ready),
        .head_data (host_tx_data),
        .not_empty (tx_st.not_empty),
        .not_full  (tx_st.not_full),
        .count     (tx_count)
    );

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (host_rx_valid),
        .push_data (host_rx_data),
        .pop       (proc_rden),
        .head_data (proc_rd_data),
        .not_empty (rx_st.not_empty),
        .not_full  (rx_st.not_full),
        .count     (rx_count)
    );

    assign host_tx_valid = tx_st.not_empty;
    assign proc_ready    = tx_st.not_full;
    assign proc_valid    = rx_st.not_empty;
    assign host_rx_ready = rx_st.not_full;

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_overflow <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            err_overflow <= sticky_next(err_overflow, proc_wren && !tx_st.not_full, err_clear);
            err_underrun <= sticky_next(err_underrun, proc_rden && !rx_st.not_empty, err_clear);
        end
    end

endmodule

// File: tb/tb_serial_console_endpoint.sv
// Directed bench with a byte scoreboard per direction and a reference occupancy model.
module tb_serial_console_endpoint;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] proc_wr_data;
    logic       proc_wren;
    logic       proc_rden;
    logic [7:0] proc_rd_data;
    logic       proc_valid;
    logic       proc_ready;
    logic [7:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_ready;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready;
    logic [4:0] tx_count;
    logic [4:0] rx_count;
    logic       err_overflow;
    logic       err_underrun;
    logic       err_clear;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         txc = 0;
    int         rxc = 0;
    logic       ovf_m = 1'b0;
    logic       und_m = 1'b0;

    serial_console_endpoint #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .proc_wr_data  (proc_wr_data),
        .proc_wren     (proc_wren),
        .proc_rden     (proc_rden),
        .proc_rd_data  (proc_rd_data),
        .proc_valid    (proc_valid),
        .proc_ready    (proc_ready),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready),
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .err_overflow  (err_overflow),
        .err_underrun  (err_underrun),
        .err_clear     (err_clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        proc_wren     = 1'b0;
        proc_rden     = 1'b0;
        host_tx_ready = 1'b0;
        host_rx_valid = 1'b0;
        err_clear     = 1'b0;
        proc_wr_data  = 8'h00;
        host_rx_data  = 8'h00;
    endtask

    // One clock with the currently driven inputs; scoreboard pops are compared
    // before the edge, status is compared 1 time unit after it.
    task automatic cycle();
        bit tx_push, tx_pop, rx_push, rx_pop;
        logic [7:0] e;
        if (!reset) begin
            tx_q.delete();
            rx_q.delete();
            txc = 0;
            rxc = 0;
            ovf_m = 1'b0;
            und_m = 1'b0;
        end else begin
            tx_push = proc_wren && (txc < 16);
            tx_pop  = host_tx_ready && (txc > 0);
            rx_push = host_rx_valid && (rxc < 16);
            rx_pop  = proc_rden && (rxc > 0);
            if (tx_pop) begin
                e = tx_q.pop_front();
                chk("host_tx_data", {24'h0, host_tx_data}, {24'h0, e});
                txc--;
            end
            if (tx_push) begin
                tx_q.push_back(proc_wr_data);
                txc++;
            end
            if (rx_pop) begin
                e = rx_q.pop_front();
                chk("proc_rd_data", {24'h0, proc_rd_data}, {24'h0, e});
                rxc--;
            end
            if (rx_push) begin
                rx_q.push_back(host_rx_data);
                rxc++;
            end
            if (err_clear) begin
                ovf_m = 1'b0;
                und_m = 1'b0;
            end
            if (proc_wren && !tx_push) ovf_m = 1'b1;
            if (proc_rden && (rxc == 0) && !rx_pop && !rx_push) und_m = 1'b1;
            else if (proc_rden && !rx_pop) und_m = 1'b1;
        end
        @(posedge clock);
        #1;
        chk("tx_count", {27'h0, tx_count}, 32'(txc));
        chk("rx_count", {27'h0, rx_count}, 32'(rxc));
        chk("tx_flags", {30'h0, host_tx_valid, proc_ready}, {30'h0, txc != 0, txc != 16});
        chk("rx_flags", {30'h0, proc_valid, host_rx_ready}, {30'h0, rxc != 0, rxc != 16});
        chk("err_flags", {30'h0, err_overflow, err_underrun}, {30'h0, ovf_m, und_m});
    endtask

    initial begin
        logic [7:0] hi [3];
        hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;
        idle();
        reset = 1'b0;

        // Reset with random strobes
        for (int i = 0; i < 2; i++) begin
            proc_wren     = 1'($urandom);
            proc_rden     = 1'($urandom);
            host_tx_ready = 1'($urandom);
            host_rx_valid = 1'($urandom);
            proc_wr_data  = 8'($urandom);
            host_rx_data  = 8'($urandom);
            cycle();
        end
        idle();
        chk("rst_status", {28'h0, proc_valid, host_tx_valid, proc_ready, host_rx_ready}, 32'h3);
        chk("rst_counts", {22'h0, tx_count, rx_count}, 32'h0);
        chk("rst_flags", {30'h0, err_overflow, err_underrun}, 32'h0);
        reset = 1'b1;

        // TX ordering
        for (int i = 0; i < 3; i++) begin
            proc_wren = 1'b1;
            proc_wr_data = hi[i];
            cycle();
        end
        idle();
        chk("tx_cnt3", {27'h0, tx_count}, 32'd3);
        chk("tx_head48", {24'h0, host_tx_data}, 32'h48);
        host_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        idle();
        chk("tx_cnt0", {27'h0, tx_count}, 32'd0);

        // TX full / overflow
        for (int i = 0; i <= 16; i++) begin
            proc_wren = 1'b1;
            proc_wr_data = 8'(i);
            cycle();
            if (i == 15) chk("tx_full_ready", {31'h0, proc_ready}, 32'h0);
        end
        idle();
        chk("tx_overflow", {31'h0, err_overflow}, 32'h1);
        chk("tx_cnt16", {27'h0, tx_count}, 32'd16);
        host_tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) cycle();
        idle();
        chk("tx_drained", {27'h0, tx_count}, 32'd0);
        err_clear = 1'b1;
        cycle();
        idle();

        // Empty TX: simultaneous push+pop pushes only
        proc_wren = 1'b1; proc_wr_data = 8'h5A; host_tx_ready = 1'b1;
        cycle();
        idle();
        chk("tx_empty_pp", {27'h0, tx_count}, 32'd1);
        host_tx_ready = 1'b1;
        cycle();
        idle();

        // RX path and underrun
        host_rx_valid = 1'b1; host_rx_data = 8'hA5;
        cycle();
        idle();
        chk("rx_valid", {31'h0, proc_valid}, 32'h1);
        chk("rx_headA5", {24'h0, proc_rd_data}, 32'hA5);
        proc_rden = 1'b1;
        cycle();
        chk("rx_no_und", {31'h0, err_underrun}, 32'h0);
        cycle();
        idle();
        chk("rx_underrun", {31'h0, err_underrun}, 32'h1);
        // clear together with a fresh underrun: set wins
        err_clear = 1'b1; proc_rden = 1'b1;
        cycle();
        idle();
        chk("set_wins", {31'h0, err_underrun}, 32'h1);
        err_clear = 1'b1;
        cycle();
        idle();
        chk("flags_clr", {30'h0, err_overflow, err_underrun}, 32'h0);

        // RX full with simultaneous push+pop
        for (int i = 0; i < 16; i++) begin
            host_rx_valid = 1'b1;
            host_rx_data = 8'(8'hC0 + i);
            cycle();
        end
        idle();
        chk("rx_full_ready", {31'h0, host_rx_ready}, 32'h0);
        host_rx_valid = 1'b1; host_rx_data = 8'hEE; proc_rden = 1'b1;
        cycle();
        idle();
        chk("rx_cnt15", {27'h0, rx_count}, 32'd15);
        chk("rx_headC1", {24'h0, proc_rd_data}, 32'hC1);
        proc_rden = 1'b1;
        for (int i = 0; i < 15; i++) cycle();
        idle();

        // Mid-operation reset
        for (int i = 0; i < 5; i++) begin
            proc_wren = 1'b1; proc_wr_data = 8'(8'h10 + i);
            host_rx_valid = (i < 3); host_rx_data = 8'(8'h20 + i);
            cycle();
        end
        idle();
        chk("pre_rst_cnt", {22'h0, tx_count, rx_count}, {22'h0, 5'd5, 5'd3});
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("mid_rst_cnt", {22'h0, tx_count, rx_count}, 32'h0);
        chk("mid_rst_vld", {30'h0, proc_valid, host_tx_valid}, 32'h0);
        proc_wren = 1'b1; proc_wr_data = 8'h31;
        host_rx_valid = 1'b1; host_rx_data = 8'h31;
        cycle();
        idle();
        chk("post_tx31", {24'h0, host_tx_data}, 32'h31);
        chk("post_rx31", {24'h0, proc_rd_data}, 32'h31);
        host_tx_ready = 1'b1; proc_rden = 1'b1;
        cycle();
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
